// File: rtl/mem_request_sequencer_pkg.sv
// Shared constants, FSM state type and command-byte helper for the memory request sequencer.
// The optional stall timeout is enabled with MEM_SEQ_TIMEOUT_EN.
package mem_request_sequencer_pkg;

  localparam logic [7:0]  MEM_OP_READ   = 8'h01;
  localparam logic [7:0]  MEM_OP_WRITE  = 8'h02;
  localparam int unsigned CMD_BYTES     = 9;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWdata,
    StRdata,
    StFin
  } seq_state_e;

  // Byte 0 (opcode) is loaded separately at start; this covers address and count bytes.
  function automatic logic [7:0] cmd_byte(logic [3:0] idx, logic [31:0] addr,
                                          logic [31:0] count);
    logic [7:0] b;
    case (idx)
      4'd1:    b = addr[31:24];
      4'd2:    b = addr[23:16];
      4'd3:    b = addr[15:8];
      4'd4:    b = addr[7:0];
      4'd5:    b = count[31:24];
      4'd6:    b = count[23:16];
      4'd7:    b = count[15:8];
      4'd8:    b = count[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_cmd_serializer.sv
// Serializes opcode, 32-bit address and 32-bit count into a registered 9-byte command stream.
module mem_cmd_serializer
  import mem_request_sequencer_pkg::*;
#(
  parameter int unsigned InterfaceWidth = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [7:0]                opcode_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               count_i,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [InterfaceWidth-1:0] cmd_data_o,
  output logic                      last_o
);

  logic [3:0] idx_q;
  logic       valid_q;
  logic [7:0] byte_q;

  assign last_o      = valid_q && (idx_q == 4'(CMD_BYTES - 1));
  assign cmd_valid_o = valid_q;
  assign cmd_data_o  = InterfaceWidth'(byte_q);

  always_ff @(posedge clk_i) begin
    if (!reset_ni || abort_i) begin
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
    end else if (start_i) begin
      idx_q   <= 4'd0;
      valid_q <= 1'b1;
      byte_q  <= opcode_i;
    end else if (valid_q && cmd_ready_i) begin
      if (last_o) begin
        idx_q   <= 4'd0;
        valid_q <= 1'b0;
        byte_q  <= 8'h00;
      end else begin
        idx_q  <= idx_q + 4'd1;
        byte_q <= cmd_byte(idx_q + 4'd1, addr_i, count_i);
      end
    end
  end

endmodule

// File: rtl/mem_request_sequencer.sv
// Block request sequencer: command serialization, write/read data metering and completion.
// Define MEM_SEQ_TIMEOUT_EN to abort transactions stalled for 65535 cycles.
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int unsigned InterfaceWidth = 8,
  parameter int unsigned AddrWidth      = 28,
  parameter int unsigned CountWidth     = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [31:0]               req_addr_i,
  input  logic [CountWidth-1:0]     req_count_i,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [InterfaceWidth-1:0] cmd_data_o,
  input  logic                      src_valid_i,
  output logic                      src_ready_o,
  input  logic [InterfaceWidth-1:0] src_data_i,
  output logic                      wr_valid_o,
  input  logic                      wr_ready_i,
  output logic [InterfaceWidth-1:0] wr_data_o,
  input  logic                      rd_valid_i,
  output logic                      rd_ready_o,
  input  logic [InterfaceWidth-1:0] rd_data_i,
  output logic                      snk_valid_o,
  input  logic                      snk_ready_i,
  output logic [InterfaceWidth-1:0] snk_data_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam logic [31:0] AddrMask = 32'((64'd1 << AddrWidth) - 64'd1);

  seq_state_e            state_q;
  logic                  write_q;
  logic [31:0]           addr_q;
  logic [CountWidth-1:0] count_q;
  logic                  done_q;
  logic                  err_q;

  logic start, cmd_last, cmd_hs, wr_hs, rd_hs, timeout;

  assign req_ready_o = (state_q == StIdle);
  assign start       = req_ready_o && req_valid_i && (req_count_i != '0);
  assign cmd_hs      = cmd_valid_o && cmd_ready_i;
  assign wr_hs       = (state_q == StWdata) && src_valid_i && wr_ready_i;
  assign rd_hs       = (state_q == StRdata) && rd_valid_i && snk_ready_i;
  assign done_o      = done_q;
  assign err_o       = err_q;

`ifdef MEM_SEQ_TIMEOUT_EN
  logic [15:0] stall_q;
  logic        active;

  assign active  = (state_q == StCmd) || (state_q == StWdata) || (state_q == StRdata);
  // Fires on the stall cycle that would bring the counter to the limit.
  assign timeout = active && !(cmd_hs || wr_hs || rd_hs) && (stall_q == TIMEOUT_LIMIT - 16'd1);

  always_ff @(posedge clk_i) begin
    if (!reset_ni || !active || cmd_hs || wr_hs || rd_hs || timeout) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  mem_cmd_serializer #(
    .InterfaceWidth(InterfaceWidth)
  ) u_cmd_serializer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .start_i    (start),
    .abort_i    (timeout),
    .opcode_i   (req_write_i ? MEM_OP_WRITE : MEM_OP_READ),
    .addr_i     (addr_q),
    .count_i    (32'(count_q)),
    .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i),
    .cmd_data_o (cmd_data_o),
    .last_o     (cmd_last)
  );

  always_comb begin
    wr_valid_o  = 1'b0;
    wr_data_o   = '0;
    src_ready_o = 1'b0;
    snk_valid_o = 1'b0;
    snk_data_o  = '0;
    rd_ready_o  = 1'b0;
    if (state_q == StWdata) begin
      wr_valid_o  = src_valid_i;
      wr_data_o   = src_data_i;
      src_ready_o = wr_ready_i;
    end
    if (state_q == StRdata) begin
      snk_valid_o = rd_valid_i;
      snk_data_o  = rd_data_i;
      rd_ready_o  = snk_ready_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i & AddrMask;
            count_q <= req_count_i;
            if (req_count_i == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= StCmd;
            end
          end
        end
        StCmd: begin
          if (timeout) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (cmd_last && cmd_ready_i) begin
            state_q <= write_q ? StWdata : StRdata;
          end
        end
        StWdata, StRdata: begin
          if (timeout) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (wr_hs || rd_hs) begin
            count_q <= count_q - CountWidth'(1);
            if (count_q == CountWidth'(1)) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Scoreboard bench for mem_request_sequencer; covers the timeout path when MEM_SEQ_TIMEOUT_EN is set.
module tb_mem_request_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = 32'd0, req_count = 32'd0;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_data;
  logic        src_valid = 1'b0, src_ready;
  logic [7:0]  src_data = 8'h00;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid = 1'b0, rd_ready;
  logic [7:0]  rd_data = 8'h00;
  logic        snk_valid, snk_ready;
  logic [7:0]  snk_data;
  logic        done, err;

  bit rand_en = 1'b0;
  bit cmd_hold = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] cmd_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] snk_q[$];
  logic       err_q[$];
  logic [7:0] exp_bytes[9];
  logic [7:0] words[8];

  always #5 clk = ~clk;

  mem_request_sequencer dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_count_i(req_count),
    .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready),
    .cmd_data_o (cmd_data),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .src_data_i (src_data),
    .wr_valid_o (wr_valid),
    .wr_ready_i (wr_ready),
    .wr_data_o  (wr_data),
    .rd_valid_i (rd_valid),
    .rd_ready_o (rd_ready),
    .rd_data_i  (rd_data),
    .snk_valid_o(snk_valid),
    .snk_ready_i(snk_ready),
    .snk_data_o (snk_data),
    .done_o     (done),
    .err_o      (err)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endfunction

  // Sink-side readies, optionally randomized.
  always @(posedge clk) begin
    #1;
    cmd_ready = cmd_hold ? 1'b0 : (rand_en ? 1'($urandom_range(0, 1)) : 1'b1);
    wr_ready  = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    snk_ready = 1'b1;
  end

  // Monitor: pops and compares on every output transfer.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (cmd_q.size() == 0) chk("cmd_extra_byte", cmd_q.size(), 1);
      else chk("cmd_byte", cmd_data, cmd_q.pop_front());
    end
    if (wr_valid && wr_ready) begin
      if (wr_q.size() == 0) chk("wr_extra_word", wr_q.size(), 1);
      else chk("wr_word", wr_data, wr_q.pop_front());
    end
    if (snk_valid && snk_ready) begin
      if (snk_q.size() == 0) chk("snk_extra_word", snk_q.size(), 1);
      else chk("snk_word", snk_data, snk_q.pop_front());
    end
    if (done) begin
      if (err_q.size() == 0) chk("done_extra", err_q.size(), 1);
      else chk("done_err", err, err_q.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push_cmd();
    foreach (exp_bytes[i]) cmd_q.push_back(exp_bytes[i]);
  endtask

  task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] c);
    int t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_count = c;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic feed_src(input int n, input bit stall);
    int i = 0;
    int t = 0;
    bit hs;
    while (i < n && t < 2000) begin
      src_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      src_data  = words[i];
      @(negedge clk); hs = src_valid && src_ready;
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    src_valid = 1'b0;
    chk("src_words_taken", i, n);
  endtask

  task automatic feed_rd(input int n);
    int i = 0;
    int t = 0;
    bit hs;
    while (i < n && t < 2000) begin
      rd_valid = 1'b1;
      rd_data  = words[i];
      @(negedge clk); hs = rd_valid && rd_ready;
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    rd_valid = 1'b0;
    chk("rd_words_taken", i, n);
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    @(negedge clk);
    while (!done && t < budget) begin
      @(negedge clk); t++;
    end
    chk(name, done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {cmd_valid, wr_valid, snk_valid, src_ready, rd_ready}, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_data", {cmd_data, wr_data, snk_data}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Write, addr 0x1234, count 3
    exp_bytes = '{8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h03};
    push_cmd();
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
    wr_q.push_back(8'hA1); wr_q.push_back(8'hB2); wr_q.push_back(8'hC3);
    err_q.push_back(1'b0);
    fork
      send_req(1'b1, 32'h0000_1234, 32'd3);
      feed_src(3, 1'b0);
    join
    @(negedge clk);
    chk("t1_done_after_last_word", done, 1);
    chk("t1_err", err, 0);
    @(posedge clk); #1;

    // Read, addr masked to 28 bits, count 2; a third word must stay unconsumed
    exp_bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02};
    push_cmd();
    words[0] = 8'h5A; words[1] = 8'h6B;
    snk_q.push_back(8'h5A); snk_q.push_back(8'h6B);
    err_q.push_back(1'b0);
    fork
      send_req(1'b0, 32'hF000_0010, 32'd2);
      feed_rd(2);
    join
    rd_valid = 1'b1; rd_data = 8'h7C;
    @(negedge clk);
    chk("t2_done_after_last_word", done, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t2_extra_rd_ready", rd_ready, 0);
      chk("t2_extra_snk_valid", snk_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;

    // Count 0: rejected without command bytes
    err_q.push_back(1'b1);
    send_req(1'b1, 32'h0000_0055, 32'd0);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_err", err, 1);
    chk("t3_no_cmd", cmd_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_no_cmd_later", cmd_valid, 0);
    @(posedge clk); #1;

    // Count 5 write under random backpressure
    rand_en = 1'b1;
    exp_bytes = '{8'h02, 8'h0B, 8'hCD, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05};
    push_cmd();
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    wr_q.push_back(8'h44); wr_q.push_back(8'h55);
    err_q.push_back(1'b0);
    fork
      send_req(1'b1, 32'hABCD_EF01, 32'd5);
      feed_src(5, 1'b1);
    join
    wait_done(20, "t4_done");
    rand_en = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset during WDATA after 2 of 4 words
    exp_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h04};
    push_cmd();
    words[0] = 8'hD1; words[1] = 8'hD2;
    wr_q.push_back(8'hD1); wr_q.push_back(8'hD2);
    fork
      send_req(1'b1, 32'h0000_0040, 32'd4);
      feed_src(2, 1'b0);
    join
    reset_n = 1'b0;
    @(posedge clk); #1;
    src_valid = 1'b1; src_data = 8'hD3; rd_valid = 1'b1;
    @(negedge clk);
    chk("t5_valids_after_reset", {cmd_valid, wr_valid, snk_valid}, 0);
    chk("t5_readies_after_reset", {src_ready, rd_ready}, 0);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_done", done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; src_valid = 1'b0; rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_after_release", {req_ready, wr_valid, cmd_valid}, 3'b100);
    @(posedge clk); #1;

    // Command stream stalled indefinitely
    cmd_hold = 1'b1;
    repeat (2) @(posedge clk); #1;
`ifdef MEM_SEQ_TIMEOUT_EN
    err_q.push_back(1'b1);
    send_req(1'b0, 32'h0000_0100, 32'd1);
    wait_done(70000, "t6_timeout_done");
    @(negedge clk);
    chk("t6_cmd_dropped", cmd_valid, 0);
    chk("t6_idle", req_ready, 1);
    @(posedge clk); #1;
`else
    begin
      int seen = 0;
      send_req(1'b0, 32'h0000_0100, 32'd1);
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("t6_no_abort", seen, 0);
      chk("t6_still_cmd_valid", cmd_valid, 1);
      chk("t6_still_opcode", cmd_data, 8'h01);
      chk("t6_not_idle", req_ready, 0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
`endif
    cmd_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("end_cmd_queue_empty", cmd_q.size(), 0);
    chk("end_wr_queue_empty", wr_q.size(), 0);
    chk("end_snk_queue_empty", snk_q.size(), 0);
    chk("end_done_queue_empty", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
